// File: rtl/cp0_exc_responder_pkg.sv
// -----------------------------------------------------------------------------
// cp0_exc_responder_pkg
// Shared constants for the CP0 exception responder. It holds the CP0 register
// numbers, the ExcCode values, the handler address, the PRId value, the
// SR/Cause field layout and the EPC helper.
// -----------------------------------------------------------------------------
package cp0_exc_responder_pkg;

   // CP0 register numbers
   localparam logic [4:0]  CP0_SR    = 5'd12;
   localparam logic [4:0]  CP0_CAUSE = 5'd13;
   localparam logic [4:0]  CP0_EPC   = 5'd14;
   localparam logic [4:0]  CP0_PRID  = 5'd15;

   // ExcCode values recorded in Cause.ExcCode
   localparam logic [4:0]  EXC_INT   = 5'd0;
   localparam logic [4:0]  EXC_ADEL  = 5'd4;
   localparam logic [4:0]  EXC_ADES  = 5'd5;
   localparam logic [4:0]  EXC_RI    = 5'd10;
   localparam logic [4:0]  EXC_OV    = 5'd12;

   // Exception handler entry point (byte address) and processor id
   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
   localparam logic [31:0] PRID_VALUE   = 32'h1937_3000;

   // Bit positions of the implemented SR / Cause fields
   localparam int unsigned SR_IE_BIT       = 0;
   localparam int unsigned SR_EXL_BIT      = 1;
   localparam int unsigned SR_IM_LSB       = 10;
   localparam int unsigned CAUSE_IP_LSB    = 10;
   localparam int unsigned CAUSE_BD_BIT    = 31;

   // Return address for an excepting instruction: a delay-slot instruction
   // returns to its branch, one word earlier (30-bit modular, so PC 0 wraps).
   function automatic logic [29:0] epc_target(input logic [29:0] pc,
                                              input logic        bd);
      logic [29:0] tgt;
      if (bd) begin
         tgt = pc - 30'd1;
      end else begin
         tgt = pc;
      end
      return tgt;
   endfunction

endpackage : cp0_exc_responder_pkg

// File: rtl/cp0_exc_responder_exc_arbiter.sv
// -----------------------------------------------------------------------------
// exc_arbiter
// Purely combinational priority logic between pending hardware interrupts and
// the synchronous exception presented by the M stage.
//
// Ports
//   i_exc_code  [4:0]  ExcCode from the M-stage exception mux (0 = none)
//   i_hwint     [5:0]  hardware interrupt lines HWInt[7:2]
//   i_im        [5:0]  SR.IM[15:10]
//   i_ie               SR.IE
//   i_exl              SR.EXL
//   o_irq              enabled interrupt pending and not blocked by EXL
//   o_exc              M-stage exception present and not blocked by EXL
//   o_int_req          o_irq | o_exc
//   o_code      [4:0]  ExcCode to record (interrupt wins over exception)
// -----------------------------------------------------------------------------
module exc_arbiter
   import cp0_exc_responder_pkg::*;
(
   input  logic [4:0] i_exc_code,
   input  logic [5:0] i_hwint,
   input  logic [5:0] i_im,
   input  logic       i_ie,
   input  logic       i_exl,
   output logic       o_irq,
   output logic       o_exc,
   output logic       o_int_req,
   output logic [4:0] o_code
);

   logic w_irq;
   logic w_exc;

   // EXL masks both sources so that a handler is never re-entered.
   assign w_irq = i_ie & ~i_exl & (|(i_hwint & i_im));
   assign w_exc = ~i_exl & (i_exc_code != 5'd0);

   assign o_irq     = w_irq;
   assign o_exc     = w_exc;
   assign o_int_req = w_irq | w_exc;

   // An interrupt taken together with an exception discards the exception;
   // the faulting instruction re-executes after the interrupt returns.
   assign o_code = w_irq ? EXC_INT : i_exc_code;

endmodule : exc_arbiter

// File: rtl/cp0_exc_responder.sv
// -----------------------------------------------------------------------------
// cp0_exc_responder
// Minimal CP0 for a five-stage MIPS pipeline: SR, Cause, EPC and PRId, the
// exception/interrupt request towards the hazard unit and the MFC0/MTC0 port.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   M_Exc   [6:2]  ExcCode of the M-stage instruction, 0 = none
//   M_PC    [31:2] word PC of the M-stage instruction
//   M_BD           M-stage instruction is in a branch delay slot
//   HWInt   [7:2]  level-sensitive hardware interrupt lines
//   eret           ERET in M
//   we             MTC0 in M
//   addr    [4:0]  CP0 register number (read and write)
//   wdata   [31:0] MTC0 data
//   rdata   [31:0] MFC0 data, combinational on addr
//   IntReq         flush and redirect to Handler (same cycle)
//   EPC_out [31:2] ERET return target
//   Handler [31:2] exception handler word address
// -----------------------------------------------------------------------------
module cp0_exc_responder
   import cp0_exc_responder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:2]  M_Exc,
   input  logic [31:2] M_PC,
   input  logic        M_BD,
   input  logic [7:2]  HWInt,
   input  logic        eret,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        IntReq,
   output logic [31:2] EPC_out,
   output logic [31:2] Handler
);

   // SR fields
   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   // Cause fields
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exc_code;
   // EPC (word address)
   logic [29:0] r_epc;

   logic        w_irq;
   logic        w_exc;
   logic        w_int_req;
   logic [4:0]  w_code;
   logic [29:0] w_epc_next;
   logic        w_wr_sr;
   logic        w_wr_epc;

   exc_arbiter u_exc_arbiter (
      .i_exc_code (M_Exc),
      .i_hwint    (HWInt),
      .i_im       (r_im),
      .i_ie       (r_ie),
      .i_exl      (r_exl),
      .o_irq      (w_irq),
      .o_exc      (w_exc),
      .o_int_req  (w_int_req),
      .o_code     (w_code)
   );

   assign w_epc_next = epc_target(M_PC, M_BD);

   // MTC0 decode; the suppression by IntReq is applied in the update block.
   assign w_wr_sr  = we & (addr == CP0_SR);
   assign w_wr_epc = we & (addr == CP0_EPC);

   // The request is held low while reset is asserted so the pipeline is not
   // redirected by a stale M-stage ExcCode during reset.
   assign IntReq  = w_int_req & reset;
   assign EPC_out = r_epc;
   assign Handler = HANDLER_ADDR[31:2];

   // CP0 register update: exception/interrupt entry, MTC0, ERET and IP sampling.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_im       <= 6'd0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ip       <= 6'd0;
         r_exc_code <= 5'd0;
         r_epc      <= 30'd0;
      end else begin
         // IP mirrors the interrupt lines regardless of any other activity.
         r_ip <= HWInt;
         if (w_int_req) begin
            // Entry into the handler wins over a colliding MTC0 and over an
            // ERET (that ERET is flushed together with the rest of the pipe).
            r_exl      <= 1'b1;
            r_exc_code <= w_code;
            r_bd       <= M_BD;
            r_epc      <= w_epc_next;
         end else begin
            if (w_wr_sr) begin
               r_im <= wdata[15:10];
               r_ie <= wdata[0];
               // A same-cycle ERET overrides the EXL bit being written.
               r_exl <= wdata[1] & ~eret;
            end else if (w_wr_epc) begin
               r_epc <= wdata[31:2];
               if (eret) begin
                  r_exl <= 1'b0;
               end else begin
                  r_exl <= r_exl;
               end
            end else begin
               if (eret) begin
                  r_exl <= 1'b0;
               end else begin
                  r_exl <= r_exl;
               end
            end
         end
      end
   end

   // MFC0 read mux; unimplemented register numbers read as zero.
   always_comb begin
      rdata = 32'd0;
      case (addr)
         CP0_SR:    rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
         CP0_CAUSE: rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
         CP0_EPC:   rdata = {r_epc, 2'b00};
         CP0_PRID:  rdata = PRID_VALUE;
         default:   rdata = 32'd0;
      endcase
   end

endmodule : cp0_exc_responder

// File: tb/tb_cp0_exc_responder.sv
module tb_cp0_exc_responder;

   logic        clk;
   logic        reset;
   logic [6:2]  M_Exc;
   logic [31:2] M_PC;
   logic        M_BD;
   logic [7:2]  HWInt;
   logic        eret;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        IntReq;
   logic [31:2] EPC_out;
   logic [31:2] Handler;

   int n_checks;
   int n_errors;

   // reference model state, kept as whole 32-bit register images
   logic [31:0] m_sr;
   logic [31:0] m_cause;
   logic [31:0] m_epc_byte;

   cp0_exc_responder dut (
      .clk     (clk),
      .reset   (reset),
      .M_Exc   (M_Exc),
      .M_PC    (M_PC),
      .M_BD    (M_BD),
      .HWInt   (HWInt),
      .eret    (eret),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .IntReq  (IntReq),
      .EPC_out (EPC_out),
      .Handler (Handler)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  exc;
      logic [29:0] pc;
      logic        bd;
      logic [5:0]  hw;
      logic        er;
      logic        wr;
      logic [4:0]  waddr;
      logic [31:0] wd;
      logic [4:0]  raddr;
      logic        exp_int;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] exc, input logic [29:0] pc, input logic bd,
                               input logic [5:0] hw, input logic er, input logic wr,
                               input logic [4:0] waddr, input logic [31:0] wd,
                               input logic [4:0] raddr, input logic exp_int,
                               input logic [31:0] exp_rd);
      vec_t v;
      v.exc = exc; v.pc = pc; v.bd = bd; v.hw = hw; v.er = er; v.wr = wr;
      v.waddr = waddr; v.wd = wd; v.raddr = raddr; v.exp_int = exp_int; v.exp_rd = exp_rd;
      return v;
   endfunction

   task automatic idle_inputs();
      M_Exc = 5'd0; M_PC = 30'd0; M_BD = 1'b0; HWInt = 6'd0;
      eret = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
   endtask

   // ---------------- reference model (register-image arithmetic) ----------
   function automatic logic [31:0] model_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc_byte;
         5'd15:   return 32'h1937_3000;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic model_irq();
      logic [31:0] lines;
      lines = {26'd0, HWInt} << 10;
      return m_sr[0] && !m_sr[1] && ((lines & m_sr & 32'h0000_FC00) != 32'd0);
   endfunction

   function automatic logic model_int();
      return model_irq() || (!m_sr[1] && M_Exc != 5'd0);
   endfunction

   task automatic model_clock();
      logic        irq;
      logic        req;
      logic [31:0] code;
      logic [31:0] pc_byte;
      irq = model_irq();
      req = model_int();
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
      if (req) begin
         code    = irq ? 32'd0 : {27'd0, M_Exc};
         pc_byte = {M_PC, 2'b00} - (M_BD ? 32'd4 : 32'd0);
         m_sr    = m_sr | 32'd2;
         m_cause = (m_cause & 32'h0000_FC00) | ({31'd0, M_BD} << 31) | (code << 2);
         m_epc_byte = pc_byte & 32'hFFFF_FFFC;
      end else begin
         if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
         else if (we && addr == 5'd14) m_epc_byte = wdata & 32'hFFFF_FFFC;
         if (eret) m_sr = m_sr & ~32'd2;
      end
   endtask

   function automatic logic [4:0] pick_exc();
      case ($urandom_range(0, 6))
         0: return 5'd4;
         1: return 5'd5;
         2: return 5'd10;
         3: return 5'd12;
         default: return 5'd0;
      endcase
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      reset = 1'b0;

      // reset state
      #2;
      M_Exc = 5'd12;
      #1;
      check("reset_intreq", {31'd0, IntReq}, 32'd0);
      check("reset_epc_out", {EPC_out, 2'b00}, 32'd0);
      addr = 5'd12; #1 check("reset_sr", rdata, 32'd0);
      addr = 5'd13; #1 check("reset_cause", rdata, 32'd0);
      addr = 5'd15; #1 check("reset_prid", rdata, 32'h1937_3000);
      check("handler", {Handler, 2'b00}, 32'h0000_4180);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;

      // directed vectors
      //            exc    pc           bd    hw     er    wr    waddr  wdata          raddr  int   rdata
      vecs[0]  = mk(5'd12, 30'h0000_0C01, 1'b0, 6'd0, 1'b0, 1'b0, 5'd0,  32'd0,          5'd13, 1'b1, 32'h0000_0030);
      vecs[1]  = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b0, 5'd0,  32'd0,          5'd14, 1'b0, 32'h0000_3004);
      vecs[2]  = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b0, 5'd0,  32'd0,          5'd12, 1'b0, 32'h0000_0002);
      vecs[3]  = mk(5'd10, 30'h0000_0100, 1'b0, 6'd0, 1'b0, 1'b0, 5'd0,  32'd0,          5'd14, 1'b0, 32'h0000_3004);
      vecs[4]  = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b1, 1'b0, 5'd0,  32'd0,          5'd12, 1'b0, 32'h0000_0000);
      vecs[5]  = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b0, 5'd0,  32'd0,          5'd14, 1'b0, 32'h0000_3004);
      vecs[6]  = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF,  5'd12, 1'b0, 32'h0000_FC03);
      vecs[7]  = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b1, 5'd12, 32'h0000_0401,  5'd12, 1'b0, 32'h0000_0401);
      vecs[8]  = mk(5'd0,  30'h0000_0C04, 1'b1, 6'd1, 1'b0, 1'b0, 5'd0,  32'd0,          5'd13, 1'b1, 32'h8000_0400);
      vecs[9]  = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b0, 5'd0,  32'd0,          5'd14, 1'b0, 32'h0000_300C);
      vecs[10] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b1, 1'b0, 5'd0,  32'd0,          5'd12, 1'b0, 32'h0000_0401);
      vecs[11] = mk(5'd4,  30'h0000_0200, 1'b0, 6'd1, 1'b0, 1'b0, 5'd0,  32'd0,          5'd13, 1'b1, 32'h0000_0400);
      vecs[12] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b1, 1'b1, 5'd12, 32'h0000_0403,  5'd12, 1'b0, 32'h0000_0401);
      vecs[13] = mk(5'd5,  30'h0000_01C0, 1'b0, 6'd0, 1'b0, 1'b1, 5'd14, 32'h0000_5000,  5'd14, 1'b1, 32'h0000_0700);
      vecs[14] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b0, 5'd0,  32'd0,          5'd13, 1'b0, 32'h0000_0014);
      vecs[15] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b1, 1'b0, 5'd0,  32'd0,          5'd12, 1'b0, 32'h0000_0401);
      vecs[16] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b1, 5'd14, 32'h0000_5000,  5'd14, 1'b0, 32'h0000_5000);
      vecs[17] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF,  5'd13, 1'b0, 32'h0000_0014);
      vecs[18] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b1, 5'd15, 32'hFFFF_FFFF,  5'd15, 1'b0, 32'h1937_3000);
      vecs[19] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b0, 1'b1, 5'd3,  32'hFFFF_FFFF,  5'd3,  1'b0, 32'h0000_0000);
      vecs[20] = mk(5'd12, 30'd0,         1'b1, 6'd0, 1'b0, 1'b0, 5'd0,  32'd0,          5'd14, 1'b1, 32'hFFFF_FFFC);
      vecs[21] = mk(5'd0,  30'd0,         1'b0, 6'd0, 1'b1, 1'b0, 5'd0,  32'd0,          5'd12, 1'b0, 32'h0000_0401);

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         M_Exc = vecs[i].exc; M_PC = vecs[i].pc; M_BD = vecs[i].bd; HWInt = vecs[i].hw;
         eret = vecs[i].er; we = vecs[i].wr; addr = vecs[i].waddr; wdata = vecs[i].wd;
         #1;
         check($sformatf("vec%0d_intreq", i), {31'd0, IntReq}, {31'd0, vecs[i].exp_int});
         @(posedge clk);
         #1;
         idle_inputs();
         addr = vecs[i].raddr;
         #1;
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
         if (vecs[i].raddr == 5'd14) check($sformatf("vec%0d_epc_out", i), {EPC_out, 2'b00}, vecs[i].exp_rd);
      end

      // asynchronous reset while inside a handler
      @(negedge clk);
      M_Exc = 5'd12; M_PC = 30'h0000_0123; M_BD = 1'b0;
      @(posedge clk);
      #1;
      addr = 5'd12;
      #1 check("midhandler_exl_set", rdata, 32'h0000_0403);
      #1 reset = 1'b0;
      #1 check("midhandler_sr", rdata, 32'd0);
      check("midhandler_intreq", {31'd0, IntReq}, 32'd0);
      check("midhandler_epc_out", {EPC_out, 2'b00}, 32'd0);
      addr = 5'd13; #1 check("midhandler_cause", rdata, 32'd0);
      addr = 5'd14; #1 check("midhandler_epc", rdata, 32'd0);
      addr = 5'd15; #1 check("midhandler_prid", rdata, 32'h1937_3000);
      idle_inputs();
      @(negedge clk);
      reset = 1'b1;
      m_sr = 32'd0; m_cause = 32'd0; m_epc_byte = 32'd0;

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         M_Exc = pick_exc();
         M_PC  = 30'($urandom);
         M_BD  = 1'($urandom_range(0, 1));
         HWInt = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         eret  = ($urandom_range(0, 5) == 0);
         we    = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 4))
            0: addr = 5'd12;
            1: addr = 5'd13;
            2: addr = 5'd14;
            3: addr = 5'd15;
            default: addr = 5'($urandom);
         endcase
         wdata = $urandom;
         if (we && addr == 5'd12 && $urandom_range(0, 1) == 1) wdata = wdata | 32'h0000_0401;
         #1;
         check("rand_intreq", {31'd0, IntReq}, {31'd0, model_int()});
         check("rand_rdata", rdata, model_read(addr));
         check("rand_epc_out", {EPC_out, 2'b00}, m_epc_byte);
         model_clock();
         @(posedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_cp0_exc_responder

// File: doc/cp0_exc_responder.md
CP0_EXC_RESPONDER -- requirements
Module: cp0_exc_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk`, with `reset` asserted at 0.
REQ-002 `clk` input 1: rising-edge clock.
REQ-003 `reset` input 1: asynchronous, active-low reset.
REQ-004 `M_Exc` input [6:2]: ExcCode from the M-stage exception mux; 0 means none.
REQ-005 `M_PC` input [31:2]: word PC of the M-stage instruction.
REQ-006 `M_BD` input 1: the M-stage instruction sits in a branch delay slot.
REQ-007 `HWInt` input [7:2]: level hardware interrupt lines.
REQ-008 `eret` input 1: an ERET is in M.
REQ-009 `we` input 1: an MTC0 write is in M.
REQ-010 `addr` input [4:0]: CP0 register number for reads and writes.
REQ-011 `wdata` input [31:0]: MTC0 data.
REQ-012 `rdata` output [31:0]: MFC0 read data.
REQ-013 `IntReq` output 1: flush the pipeline and redirect to the handler.
REQ-014 `EPC_out` output [31:2]: ERET return target.
REQ-015 `Handler` output [31:2]: constant handler address 0x00004180 >> 2.

Function
REQ-016 The block SHALL hold four CP0 registers.
- SR (12): IM[15:10], EXL[1], IE[0].
- Cause (13): BD[31], IP[15:10], ExcCode[6:2].
- EPC (14).
- PRId (15): constant 0x19373000.
REQ-017 The interrupt request SHALL be computed as irq = IE & ~EXL & |(HWInt & IM).
REQ-018 The exception request SHALL be computed as exc = ~EXL & (M_Exc != 0).
REQ-019 `IntReq` SHALL equal irq | exc, combinationally, in the same cycle.
REQ-020 If irq and exc are both high, the interrupt SHALL win: ExcCode 0 is recorded and M_Exc is discarded.
REQ-021 On a clock edge with `IntReq`=1, the block SHALL update, with the new values visible from the next cycle:
- EXL <= 1.
- Cause.ExcCode <= (irq ? 0 : M_Exc).
- Cause.BD <= M_BD.
- EPC <= M_BD ? M_PC-1 (word units) : M_PC.
REQ-022 Cause.IP SHALL be loaded from `HWInt` on every clock edge, independent of EXL, IE and `we`.
REQ-023 While EXL=1, new exceptions and interrupts SHALL be ignored (no nesting); `IntReq` stays 0 and EPC is held.
REQ-024 `eret` SHALL clear EXL on the clock edge.
REQ-025 `EPC_out` SHALL equal the current EPC register combinationally; the flush for ERET is done by the hazard unit, not by this block.
REQ-026 When `IntReq`=0, `we` SHALL write wdata to SR (addr 12) or EPC (addr 14, wdata[31:2]).
REQ-027 Writes to Cause, PRId and unimplemented addresses SHALL be ignored.
REQ-028 When `IntReq`=1 and `we`=1 in the same cycle, the write SHALL be suppressed and the exception/interrupt update applies.
REQ-029 When `eret`=1 and `we`=1 to SR in the same cycle, the MTC0 value SHALL be written first and EXL then forced to 0.
REQ-030 `rdata` SHALL be combinational on `addr`.
- SR: {16'b0, IM, 8'b0, EXL, IE}.
- Cause: {BD, 15'b0, IP, 3'b0, ExcCode, 2'b0}.
- EPC: {EPC, 2'b00}.
- PRId: the constant.
- Any other address: 0.
REQ-031 EPC arithmetic SHALL be a 30-bit modular subtract; M_PC=0 with BD=1 wraps to 0x3FFFFFFF.

Reset
REQ-032 Reset asserted SHALL force, asynchronously: SR=0, Cause=0, EPC=0.
REQ-033 Under reset, the outputs SHALL therefore be `IntReq`=0, `EPC_out`=0 and `rdata`=PRId at addr 15, otherwise 0.
REQ-034 Reset release SHALL be synchronised externally; no internal state survives a reset asserted mid-handler (EXL returns to 0).

Structure
REQ-035 The shared header SHALL hold:
- CP0 register numbers: 12, 13, 14, 15.
- ExcCodes: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- Handler address 0x4180.
- PRId value.
REQ-036 The irq/exc priority and ExcCode select SHALL sit in one combinational sub-module, `exc_arbiter`; the register file and update logic stay in the top module.

Verification
REQ-037 Arithmetic overflow: M_Exc=12, M_PC=0x00003004>>2, BD=0, EXL=0.
- Same cycle: `IntReq`=1.
- Next cycle: Cause.ExcCode=12, EPC read = 0x00003004, SR.EXL=1.
REQ-038 Interrupt in a delay slot: SR=0x00000401 (IM[10], IE=1), HWInt[2]=1, M_PC=0x3010>>2, BD=1.
- Same cycle: `IntReq`=1.
- After the edge: ExcCode=0, BD=1, EPC read = 0x0000300C.
REQ-039 Simultaneous interrupt and AdEL: HWInt[2]=1 enabled together with M_Exc=4.
- Required: ExcCode=0 recorded; AdEL discarded.
REQ-040 Nesting blocked: with EXL=1, apply M_Exc=10.
- Required: `IntReq`=0 and EPC unchanged.
- Then eret=1 -> EXL=0 next cycle, and `EPC_out` keeps its value.
REQ-041 Write collision: we=1, addr=14, wdata=0x5000, with M_Exc=5 in the same cycle.
- Required: EPC = M_PC, not 0x5000.
- A later we to addr 14 with `IntReq`=0 -> EPC read = 0x5000.
REQ-042 Asynchronous reset mid-handler: assert reset low between edges while EXL=1.
- Required: SR, Cause, EPC all 0 immediately.
- Read addr 15 -> 0x19373000.
